pcm5102_i2s_tx: RTL and testbench

- Free-running I2S master transmitter that drives a PCM5102 stereo audio DAC in 3-wire mode (BCK, LRCK, DIN; no system clock).
- Takes two parallel two's-complement samples (left, right) from an upstream source such as an NCO sine generator.
- Captures both samples once per frame and shifts them out MSB-first.
- With the defaults and a 48 MHz clk: BCK = 3 MHz, 64 BCK per frame, sample rate 46.875 kHz.

---
 rtl/pcm5102_i2s_tx.sv | 92 +++++++++
 tb/tb_pcm5102_i2s_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pcm5102_i2s_tx.sv
// pcm5102_i2s_tx: free-running I2S master transmitter for a PCM5102 DAC in
// 3-wire mode (BCK, LRCK, DIN). Both channel samples are captured once per
// frame and shifted out MSB-first, one bit per BCK falling edge.
// Optional build macro PCM5102_LEFT_JUSTIFIED_EN selects left-justified
// framing (MSB aligned with the LRCK edge) instead of standard I2S.
module pcm5102_i2s_tx #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned SLOT_WIDTH = 32,
   parameter int unsigned BCK_HALF   = 8
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [DATA_WIDTH-1:0] left,
   input  logic [DATA_WIDTH-1:0] right,
   output logic                  din,
   output logic                  bck,
   output logic                  lrck
);

   localparam int unsigned FRAME_LEN = 2 * SLOT_WIDTH;
   localparam int unsigned POS_W     = $clog2(FRAME_LEN);
   localparam int unsigned CNT_W     = $clog2(BCK_HALF);
`ifdef PCM5102_LEFT_JUSTIFIED_EN
   // MSB sits at slot bit 0 (same BCK as the LRCK edge)
   localparam int unsigned PAD_SHIFT = SLOT_WIDTH - DATA_WIDTH;
`else
   // MSB sits at slot bit 1 (one BCK after the LRCK edge)
   localparam int unsigned PAD_SHIFT = SLOT_WIDTH - 1 - DATA_WIDTH;
`endif

   logic [CNT_W-1:0]      cnt;
   logic [POS_W-1:0]      pos;
   logic [DATA_WIDTH-1:0] left_q;
   logic [DATA_WIDTH-1:0] right_q;

   logic                  wrap_c;
   logic                  fall_c;
   logic [POS_W-1:0]      pos_nxt_c;
   logic                  capture_c;
   logic                  right_slot_c;
   logic [POS_W-1:0]      k_c;
   logic [DATA_WIDTH-1:0] word_c;
   logic [SLOT_WIDTH-1:0] slot_c;
   logic [SLOT_WIDTH-1:0] slot_shift_c;
   logic                  din_nxt_c;

   // Next frame position and the serial bit that goes with it
   always_comb begin
      wrap_c       = (cnt == CNT_W'(BCK_HALF - 1));
      fall_c       = wrap_c && bck;
      pos_nxt_c    = (pos == POS_W'(FRAME_LEN - 1)) ? '0 : pos + POS_W'(1);
      capture_c    = (pos_nxt_c == '0);
      right_slot_c = (pos_nxt_c >= POS_W'(SLOT_WIDTH));
      k_c          = right_slot_c ? pos_nxt_c - POS_W'(SLOT_WIDTH) : pos_nxt_c;
      // on the capture edge the fresh left input is used, not the stale latch
      word_c       = right_slot_c ? right_q : (capture_c ? left : left_q);
      // slot bit k lives at slot_c[SLOT_WIDTH-1-k]; padding is zero
      slot_c       = SLOT_WIDTH'(word_c) << PAD_SHIFT;
      slot_shift_c = slot_c << k_c;
      din_nxt_c    = slot_shift_c[SLOT_WIDTH-1];
   end

   // BCK divider, frame position, sample latches and registered outputs
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         cnt     <= '0;
         bck     <= 1'b0;
         pos     <= POS_W'(FRAME_LEN - 1);
         lrck    <= 1'b0;
         din     <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
      end else begin
         if (wrap_c) begin
            cnt <= '0;
            bck <= ~bck;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         if (fall_c) begin
            pos  <= pos_nxt_c;
            lrck <= right_slot_c;
            din  <= din_nxt_c;
            if (capture_c) begin
               left_q  <= left;
               right_q <= right;
            end
         end
      end
   end

endmodule

// File: tb/tb_pcm5102_i2s_tx.sv
// tb_pcm5102_i2s_tx: randomized self-checking bench for pcm5102_i2s_tx.
// The reference model derives every output from the clk edge count since
// reset release and the samples present at each frame's capture edge.
module tb_pcm5102_i2s_tx;

   localparam int DW = 16;
   localparam int SW = 32;
   localparam int BH = 8;

   logic          clk;
   logic          arst;
   logic [DW-1:0] left;
   logic [DW-1:0] right;
   logic          din;
   logic          bck;
   logic          lrck;

   int n_chk;
   int n_pass;

   // reference model state
   int            n;
   int            pos;
   bit            have_pos;
   logic [DW-1:0] cap_l;
   logic [DW-1:0] cap_r;

   // observation state for framing checks
   logic prev_lrck;
   logic prev_bck;
   int   last_rise;

   pcm5102_i2s_tx #(
      .DATA_WIDTH(DW),
      .SLOT_WIDTH(SW),
      .BCK_HALF  (BH)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .left (left),
      .right(right),
      .din  (din),
      .bck  (bck),
      .lrck (lrck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
   endtask

   task automatic model_reset();
      n         = 0;
      pos       = 0;
      have_pos  = 1'b0;
      cap_l     = '0;
      cap_r     = '0;
      prev_lrck = 1'b0;
      prev_bck  = 1'b0;
      last_rise = -1;
   endtask

   // One clk cycle: advance the model at the rising edge, check at the falling edge
   task automatic tick();
      logic [DW-1:0] w;
      int            k;
      logic          e_bck;
      logic          e_lrck;
      logic          e_din;
      @(posedge clk);
      if (arst) begin
         n++;
         if (n % (2 * BH) == 0) begin
            pos      = ((n / (2 * BH)) - 1) % (2 * SW);
            have_pos = 1'b1;
            if (pos == 0) begin
               cap_l = left;
               cap_r = right;
            end
         end
      end
      e_bck  = 1'((n / BH) % 2);
      e_lrck = 1'b0;
      e_din  = 1'b0;
      if (have_pos) begin
         e_lrck = (pos >= SW);
         w      = (pos < SW) ? cap_l : cap_r;
         k      = pos % SW;
`ifdef PCM5102_LEFT_JUSTIFIED_EN
         if (k < DW) e_din = w[DW-1-k];
`else
         if (k >= 1 && k <= DW) e_din = w[DW-k];
`endif
      end
      @(negedge clk);
      chk("bck",  32'(bck),  32'(e_bck));
      chk("lrck", 32'(lrck), 32'(e_lrck));
      chk("din",  32'(din),  32'(e_din));
      if (lrck !== prev_lrck) begin
         chk("lrck_on_bck_fall", 32'({prev_bck, bck}), 32'(2'b10));
         if (lrck) begin
            if (last_rise >= 0) chk("lrck_period", 32'(n - last_rise), 32'd1024);
            last_rise = n;
         end else if (last_rise >= 0) begin
            chk("lrck_high_time", 32'(n - last_rise), 32'd512);
         end
      end
      prev_lrck = lrck;
      prev_bck  = bck;
   endtask

   task automatic run(input int cycles, input int change_odds);
      for (int i = 0; i < cycles; i++) begin
         if (change_odds > 0 && $urandom_range(change_odds - 1) == 0) left  = DW'($urandom);
         if (change_odds > 0 && $urandom_range(change_odds - 1) == 0) right = DW'($urandom);
         tick();
      end
   endtask

   initial begin
      int guard;
      n_chk  = 0;
      n_pass = 0;
      model_reset();
      arst  = 1'b0;
      left  = DW'($urandom);
      right = DW'($urandom);

      // reset held with random inputs: everything stays low
      run(12, 2);
      arst = 1'b1;

      // fixed pattern for data ordering
      left  = 16'h8001;
      right = 16'h7FFE;
      run(3 * 1024 + 64, 0);

      // capture: swap left mid-left-slot, current frame keeps the old word
      left = 16'hAAAA;
      run(1100, 0);
      guard = 0;
      while ((n % 1024) != 200 && guard < 2048) begin
         tick();
         guard++;
      end
      chk("wait_mid_left", 32'(guard < 2048), 32'd1);
      left = 16'h5555;
      run(2100, 0);

      // randomized free run
      run(4000, 40);

      // mid-frame reset during the right slot
      guard = 0;
      while (lrck !== 1'b1 && guard < 2048) begin
         tick();
         guard++;
      end
      chk("wait_right_slot", 32'(guard < 2048), 32'd1);
      run(37, 0);
      arst = 1'b0;
      #1;
      chk("async_rst_bck",  32'(bck),  32'd0);
      chk("async_rst_lrck", 32'(lrck), 32'd0);
      chk("async_rst_din",  32'(din),  32'd0);
      model_reset();
      run(7, 3);
      arst = 1'b1;
      left  = 16'h8001;
      right = 16'h7FFE;
      run(2100, 0);
      run(1500, 30);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
